// File: rtl/ifft_output_reorder.sv
// Reorders bit-reversed IFFT result frames into natural order through a
// ping-pong double buffer, replaying each frame on a valid/ready output port.
module ifft_output_reorder #(
  parameter int NFFT   = 128,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              end_FFT,
  input  logic              data_valid,
  input  logic [DATA_W-1:0] in_re,
  input  logic [DATA_W-1:0] in_im,
  input  logic              out_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_re,
  output logic [DATA_W-1:0] out_im,
  output logic              out_last,
  output logic              overflow,
  output logic              frame_err
);

  localparam int AW = $clog2(NFFT);
  localparam logic [AW-1:0] LAST_IDX = AW'(NFFT - 1);

  typedef enum logic [0:0] {
    R_IDLE   = 1'b0,
    R_STREAM = 1'b1
  } rd_state_t;

  function automatic logic [AW-1:0] bitrev(input logic [AW-1:0] a);
    logic [AW-1:0] r;
    for (int i = 0; i < AW; i++) begin
      r[i] = a[AW-1-i];
    end
    return r;
  endfunction

  logic [2*DATA_W-1:0] r_mem [0:2*NFFT-1];

  logic [AW-1:0] r_wr_cnt;
  logic          r_wr_bank;
  logic          r_drop;
  logic [1:0]    r_full;

  logic [AW-1:0] r_rd_cnt;
  logic          r_rd_bank;
  rd_state_t     r_state;

  logic          w_start;
  logic [AW-1:0] w_idx;
  logic          w_drop;
  logic          w_we;
  logic          w_wr_done;
  logic [1:0]    w_set;
  logic [1:0]    w_clr;

  rd_state_t     w_nxt_state;
  logic [AW-1:0] w_nxt_cnt;
  logic          w_nxt_bank;
  logic          w_rd_clr;
  logic          w_hs;
  logic          w_nxt_valid;
  logic [2*DATA_W-1:0] w_rd_word;

  // A frame starts on end_FFT or at index 0; the drop decision is latched for the whole frame.
  always_comb begin
    w_start   = data_valid & (end_FFT | (r_wr_cnt == '0));
    w_idx     = end_FFT ? '0 : r_wr_cnt;
    w_drop    = w_start ? r_full[r_wr_bank] : r_drop;
    w_we      = data_valid & ~w_drop;
    w_wr_done = data_valid & (w_idx == LAST_IDX);
    if (w_wr_done & ~w_drop) begin
      w_set = r_wr_bank ? 2'b10 : 2'b01;
    end else begin
      w_set = 2'b00;
    end
  end

  always_ff @(posedge clk) begin
    if (w_we) begin
      r_mem[{r_wr_bank, bitrev(w_idx)}] <= {in_re, in_im};
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_cnt  <= '0;
      r_wr_bank <= 1'b0;
      r_drop    <= 1'b0;
      overflow  <= 1'b0;
      frame_err <= 1'b0;
    end else if (data_valid) begin
      r_drop <= w_drop;
      if (w_wr_done) begin
        r_wr_cnt <= '0;
        if (!w_drop) begin
          r_wr_bank <= ~r_wr_bank;
        end
      end else begin
        r_wr_cnt <= w_idx + AW'(1);
      end
      if (w_start && r_full[r_wr_bank]) begin
        overflow <= 1'b1;
      end
      if (end_FFT && (r_wr_cnt != '0)) begin
        frame_err <= 1'b1;
      end
    end
  end

  // Writer may set one bank while the reader clears the other in the same cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_full <= 2'b00;
    end else begin
      r_full <= (r_full | w_set) & ~w_clr;
    end
  end

  assign w_hs  = out_valid & out_ready;
  assign w_clr = w_rd_clr ? (r_rd_bank ? 2'b10 : 2'b01) : 2'b00;

  always_comb begin
    w_nxt_state = r_state;
    w_nxt_cnt   = r_rd_cnt;
    w_nxt_bank  = r_rd_bank;
    w_rd_clr    = 1'b0;
    case (r_state)
      R_IDLE: begin
        if (r_full[r_rd_bank]) begin
          w_nxt_state = R_STREAM;
        end else begin
          w_nxt_state = R_IDLE;
        end
      end
      R_STREAM: begin
        if (w_hs) begin
          if (r_rd_cnt == LAST_IDX) begin
            w_rd_clr    = 1'b1;
            w_nxt_bank  = ~r_rd_bank;
            w_nxt_cnt   = '0;
            w_nxt_state = r_full[~r_rd_bank] ? R_STREAM : R_IDLE;
          end else begin
            w_nxt_cnt = r_rd_cnt + AW'(1);
          end
        end else begin
          w_nxt_cnt = r_rd_cnt;
        end
      end
      default: begin
        w_nxt_state = R_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= R_IDLE;
      r_rd_cnt  <= '0;
      r_rd_bank <= 1'b0;
    end else begin
      r_state   <= w_nxt_state;
      r_rd_cnt  <= w_nxt_cnt;
      r_rd_bank <= w_nxt_bank;
    end
  end

  // Output register re-reads the next (or same, when stalled) address every cycle.
  assign w_nxt_valid = (r_state == R_STREAM) && (w_nxt_state == R_STREAM);
  assign w_rd_word   = r_mem[{w_nxt_bank, w_nxt_cnt}];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid <= 1'b0;
      out_re    <= '0;
      out_im    <= '0;
      out_last  <= 1'b0;
    end else if (w_nxt_valid) begin
      out_valid <= 1'b1;
      out_re    <= w_rd_word[2*DATA_W-1:DATA_W];
      out_im    <= w_rd_word[DATA_W-1:0];
      out_last  <= (w_nxt_cnt == LAST_IDX);
    end else begin
      out_valid <= 1'b0;
      out_re    <= '0;
      out_im    <= '0;
      out_last  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_ifft_output_reorder.sv
// Scoreboard bench for ifft_output_reorder with NFFT=8: directed frames are
// pushed as natural-order expectations and a monitor pops them on each handshake.
module tb_ifft_output_reorder;

  localparam int NFFT = 8;
  localparam int DW   = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          end_FFT = 1'b0;
  logic          data_valid = 1'b0;
  logic [DW-1:0] in_re = '0;
  logic [DW-1:0] in_im = '0;
  logic          out_ready = 1'b0;
  logic          out_valid;
  logic [DW-1:0] out_re;
  logic [DW-1:0] out_im;
  logic          out_last;
  logic          overflow;
  logic          frame_err;

  ifft_output_reorder #(.NFFT(NFFT), .DATA_W(DW)) dut (
    .clk(clk), .rst(rst), .end_FFT(end_FFT), .data_valid(data_valid),
    .in_re(in_re), .in_im(in_im), .out_ready(out_ready),
    .out_valid(out_valid), .out_re(out_re), .out_im(out_im),
    .out_last(out_last), .overflow(overflow), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [DW-1:0] re;
    logic [DW-1:0] im;
    logic          last;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   br [0:7] = '{0, 4, 2, 6, 1, 5, 3, 7};
  int   run_len  = 0;
  int   last_run = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: pops on each handshake, checks stall stability, tracks valid run length
  initial begin
    logic          stalled;
    logic [DW-1:0] h_re, h_im;
    logic          h_last;
    exp_t          e;
    stalled = 1'b0;
    h_re = '0; h_im = '0; h_last = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        stalled = 1'b0;
        run_len = 0;
      end else begin
        if (out_valid) run_len++;
        else begin
          if (run_len > 0) last_run = run_len;
          run_len = 0;
        end
        if (stalled) begin
          check("hold_valid", {31'd0, out_valid}, 32'd1);
          check("hold_re", {16'd0, out_re}, {16'd0, h_re});
          check("hold_im", {16'd0, out_im}, {16'd0, h_im});
          check("hold_last", {31'd0, out_last}, {31'd0, h_last});
        end
        if (out_valid && out_ready) begin
          if (sb.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL extra_out: got re=%0h expected no output", out_re);
          end else begin
            e = sb.pop_front();
            check("out_re", {16'd0, out_re}, {16'd0, e.re});
            check("out_im", {16'd0, out_im}, {16'd0, e.im});
            check("out_last", {31'd0, out_last}, {31'd0, e.last});
          end
          stalled = 1'b0;
        end else if (out_valid) begin
          stalled = 1'b1;
          h_re = out_re; h_im = out_im; h_last = out_last;
        end else begin
          stalled = 1'b0;
        end
      end
    end
  end

  task automatic send_frame(input logic [DW-1:0] base, input bit kept);
    exp_t e;
    logic [DW-1:0] v;
    if (kept) begin
      for (int i = 0; i < NFFT; i++) begin
        v = base + DW'(i);
        e.re = v; e.im = ~v; e.last = (i == NFFT - 1);
        sb.push_back(e);
      end
    end
    for (int j = 0; j < NFFT; j++) begin
      @(posedge clk); #1;
      v = base + DW'(br[j]);
      data_valid = 1'b1;
      end_FFT    = (j == 0);
      in_re      = v;
      in_im      = ~v;
    end
  endtask

  task automatic idle();
    @(posedge clk); #1;
    data_valid = 1'b0;
    end_FFT    = 1'b0;
  endtask

  task automatic wait_drain();
    int c;
    c = 0;
    while (sb.size() != 0 && c < 300) begin
      @(posedge clk);
      c++;
    end
    check("drain_left", sb.size(), 32'd0);
    repeat (4) @(posedge clk);
    #1;
    check("idle_valid", {31'd0, out_valid}, 32'd0);
  endtask

  initial begin
    int c;
    bit pat [0:3] = '{1'b1, 1'b0, 1'b0, 1'b1};
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", {31'd0, out_valid}, 32'd0);
    check("rst_re", {16'd0, out_re}, 32'd0);
    check("rst_last", {31'd0, out_last}, 32'd0);
    check("rst_overflow", {31'd0, overflow}, 32'd0);
    check("rst_frame_err", {31'd0, frame_err}, 32'd0);
    rst = 1'b1;

    // 1: single frame, latency
    out_ready = 1'b1;
    send_frame(16'h0000, 1'b1);
    idle();
    @(posedge clk); #1;
    check("lat_1cyc", {31'd0, out_valid}, 32'd0);
    @(posedge clk); #1;
    check("lat_2cyc", {31'd0, out_valid}, 32'd1);
    wait_drain();

    // 2: back-to-back frames, no gap
    last_run = 0;
    send_frame(16'h0100, 1'b1);
    send_frame(16'h0200, 1'b1);
    idle();
    wait_drain();
    check("no_gap_run", last_run, 32'd16);
    check("overflow_clear", {31'd0, overflow}, 32'd0);

    // 3: out_ready toggling 1,0,0,1
    out_ready = 1'b0;
    send_frame(16'h0300, 1'b1);
    idle();
    c = 0;
    while (sb.size() != 0 && c < 200) begin
      @(posedge clk); #1;
      out_ready = pat[c % 4];
      c++;
    end
    out_ready = 1'b1;
    wait_drain();

    // 4: three frames while stalled, third dropped
    out_ready = 1'b0;
    send_frame(16'h0400, 1'b1);
    send_frame(16'h0500, 1'b1);
    send_frame(16'h0600, 1'b0);
    idle();
    @(posedge clk); #1;
    check("overflow_set", {31'd0, overflow}, 32'd1);
    out_ready = 1'b1;
    wait_drain();

    // 5: early end_FFT after 3 samples
    check("frame_err_pre", {31'd0, frame_err}, 32'd0);
    for (int j = 0; j < 3; j++) begin
      @(posedge clk); #1;
      data_valid = 1'b1;
      end_FFT    = (j == 0);
      in_re      = 16'h7700 + DW'(j);
      in_im      = 16'h1234;
    end
    send_frame(16'h0800, 1'b1);
    idle();
    @(posedge clk); #1;
    check("frame_err_set", {31'd0, frame_err}, 32'd1);
    wait_drain();

    // 6: reset mid-readout
    send_frame(16'h0900, 1'b1);
    idle();
    repeat (5) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    check("mid_rst_valid", {31'd0, out_valid}, 32'd0);
    check("mid_rst_re", {16'd0, out_re}, 32'd0);
    check("mid_rst_im", {16'd0, out_im}, 32'd0);
    check("mid_rst_overflow", {31'd0, overflow}, 32'd0);
    check("mid_rst_frame_err", {31'd0, frame_err}, 32'd0);
    sb.delete();
    @(posedge clk); #1;
    rst = 1'b1;
    send_frame(16'h0A00, 1'b1);
    idle();
    wait_drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
